// File: rtl/attempt_guard.sv
// attempt_guard: check-result controller for the encoded lock.
// A full per-digit match opens the lock; a mismatch pulses the global restart
// for RESTART_HOLD cycles, and MAX_FAIL consecutive mismatches trigger a timed
// lockout of LOCK_CYCLES cycles during which checks are ignored. All outputs
// are Moore-decoded and registered.
module attempt_guard #(
    parameter int DIGITS       = 4,
    parameter int MAX_FAIL     = 3,
    parameter int LOCK_CYCLES  = 1000,
    parameter int RESTART_HOLD = 2,
    localparam int FW = $clog2(MAX_FAIL + 1),
    localparam int HW = $clog2(RESTART_HOLD + 1),
    localparam int TW = $clog2(LOCK_CYCLES + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [DIGITS-1:0] IN,
    output logic              restart,
    output logic              unlocked,
    output logic              locked_out,
    output logic [FW-1:0]     fail_cnt,
    output logic [DIGITS-1:0] miss_mask
);

    typedef enum logic [1:0] {
        ST_RESTART = 2'd0,
        ST_IDLE    = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [FW-1:0]     fail_cnt_q, fail_cnt_d;
    logic [DIGITS-1:0] miss_mask_q, miss_mask_d;
    logic              restart_q, restart_d;
    logic              unlocked_q, unlocked_d;
    logic              locked_out_q, locked_out_d;

    // A check succeeds only when every digit reports a match.
    function automatic logic all_match(input logic [DIGITS-1:0] flags);
        return &flags;
    endfunction

    // Next-state, counter and capture logic; EN only matters in IDLE and OPEN.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        timer_d     = timer_q;
        fail_cnt_d  = fail_cnt_q;
        miss_mask_d = miss_mask_q;
        case (state_q)
            ST_RESTART: begin
                // Leaving on the final count keeps restart high exactly RESTART_HOLD cycles.
                if (hold_q <= HW'(1)) begin
                    state_d = ST_IDLE;
                    hold_d  = {HW{1'b0}};
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            ST_IDLE: begin
                if (EN) begin
                    if (all_match(IN)) begin
                        state_d    = ST_OPEN;
                        fail_cnt_d = {FW{1'b0}};
                    end else begin
                        miss_mask_d = ~IN;
                        // Saturating compare: the count can never pass MAX_FAIL.
                        if (fail_cnt_q >= FW'(MAX_FAIL - 1)) begin
                            state_d    = ST_LOCKOUT;
                            fail_cnt_d = FW'(MAX_FAIL);
                            timer_d    = TW'(LOCK_CYCLES);
                        end else begin
                            state_d    = ST_RESTART;
                            fail_cnt_d = fail_cnt_q + FW'(1);
                            hold_d     = HW'(RESTART_HOLD);
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPEN: begin
                // Any strobe while open is a relock, whatever the digits say.
                if (EN) begin
                    state_d    = ST_RESTART;
                    hold_d     = HW'(RESTART_HOLD);
                    fail_cnt_d = {FW{1'b0}};
                end else begin
                    state_d = ST_OPEN;
                end
            end
            ST_LOCKOUT: begin
                if (timer_q <= TW'(1)) begin
                    state_d    = ST_IDLE;
                    timer_d    = {TW{1'b0}};
                    fail_cnt_d = {FW{1'b0}};
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = ST_RESTART;
                hold_d  = HW'(RESTART_HOLD);
            end
        endcase
    end

    // Moore output decode from the upcoming state so the outputs can be registered.
    always_comb begin
        restart_d    = 1'b1;
        unlocked_d   = 1'b0;
        locked_out_d = 1'b0;
        case (state_d)
            ST_RESTART: begin
                restart_d    = 1'b1;
                unlocked_d   = 1'b0;
                locked_out_d = 1'b0;
            end
            ST_IDLE: begin
                restart_d    = 1'b0;
                unlocked_d   = 1'b0;
                locked_out_d = 1'b0;
            end
            ST_OPEN: begin
                restart_d    = 1'b0;
                unlocked_d   = 1'b1;
                locked_out_d = 1'b0;
            end
            ST_LOCKOUT: begin
                restart_d    = 1'b1;
                unlocked_d   = 1'b0;
                locked_out_d = 1'b1;
            end
            default: begin
                restart_d    = 1'b1;
                unlocked_d   = 1'b0;
                locked_out_d = 1'b0;
            end
        endcase
    end

    // State and output registers; RST wins over any strobe in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_RESTART;
            hold_q       <= HW'(RESTART_HOLD);
            timer_q      <= {TW{1'b0}};
            fail_cnt_q   <= {FW{1'b0}};
            miss_mask_q  <= {DIGITS{1'b0}};
            restart_q    <= 1'b1;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            timer_q      <= timer_d;
            fail_cnt_q   <= fail_cnt_d;
            miss_mask_q  <= miss_mask_d;
            restart_q    <= restart_d;
            unlocked_q   <= unlocked_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign restart    = restart_q;
    assign unlocked   = unlocked_q;
    assign locked_out = locked_out_q;
    assign fail_cnt   = fail_cnt_q;
    assign miss_mask  = miss_mask_q;

endmodule

// File: doc/attempt_guard.md
# attempt_guard

Parametrised check-result controller for the encoded lock. It takes a one-cycle check strobe and a per-digit match vector from the comparator stage. A full match opens the lock. A mismatch drives `restart`, the global reset that returns all entry modules to their start state. After `MAX_FAIL` consecutive failed attempts it holds the design in a timed lockout, during which no further check is accepted.

## Interface
- `DIGITS`, default 4: number of code digits, i.e. the width of `IN` and `miss_mask`.
- `MAX_FAIL`, default 3: consecutive failed checks that trigger lockout. Must be ≥1.
- `LOCK_CYCLES`, default 1000: length of the lockout in CLK cycles. Must be ≥1.
- `RESTART_HOLD`, default 2: number of cycles `restart` stays high after a fail, a relock or reset. Must be ≥1.

Ports:
- `CLK`  in  1  clock; all state changes on its rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `EN`  in  1  check strobe; one-cycle pulse, `IN` is valid in the same cycle.
- `IN`  in  DIGITS  per-digit match flags; 1 means the digit matches.
- `restart`  out  1  global restart to the entry modules; registered.
- `unlocked`  out  1  lock-open indication; registered.
- `locked_out`  out  1  lockout in progress; registered.
- `fail_cnt`  out  $clog2(MAX_FAIL+1)  consecutive failed checks so far.
- `miss_mask`  out  DIGITS  ~IN captured at the most recent failed check.

## Operation
- The FSM has four states: RESTART, IDLE, OPEN and LOCKOUT. All outputs are decoded from registered state (Moore).
- Output values per state:
  - RESTART: `restart`=1, `unlocked`=0, `locked_out`=0.
  - IDLE: `restart`=0, `unlocked`=0, `locked_out`=0.
  - OPEN: `restart`=0, `unlocked`=1, `locked_out`=0.
  - LOCKOUT: `restart`=1, `unlocked`=0, `locked_out`=1.
- RST: state←RESTART, hold counter←RESTART_HOLD, `fail_cnt`←0, `miss_mask`←0, lockout timer←0. RST has priority over every other event, including EN in the same cycle.
- Reset values of outputs: `restart`=1, `unlocked`=0, `locked_out`=0, `fail_cnt`=0, `miss_mask`=0.
- RESTART: the hold counter decrements each cycle. When it reaches 0, state goes to IDLE. EN is ignored.
- IDLE, EN with `IN` all ones: state goes to OPEN and `fail_cnt` is set to 0. `miss_mask` is unchanged.
- IDLE, EN with any `IN` bit 0:
  - `miss_mask`←~IN and `fail_cnt` increments by 1.
  - If the new count equals MAX_FAIL, state goes to LOCKOUT and the timer is loaded with LOCK_CYCLES.
  - Otherwise state goes to RESTART and the hold counter is reloaded.
- OPEN: any EN is treated as a relock request, whatever `IN` holds. State goes to RESTART, and `fail_cnt` stays 0.
- LOCKOUT: the timer decrements each cycle. When it expires, state goes to IDLE and `fail_cnt` is set to 0. EN is ignored.
- `fail_cnt` never exceeds MAX_FAIL and never wraps.
- With EN low, IDLE and OPEN hold their state indefinitely.

## Timing
- EN sampled high at edge t produces new outputs from t+1. The effective latency is 1 cycle.
- In steady operation `restart` stays high for exactly RESTART_HOLD cycles per fail or relock.
- After RST is released, `restart` stays high for exactly RESTART_HOLD further cycles.
- `locked_out` and `restart` stay high for exactly LOCK_CYCLES cycles in LOCKOUT. IDLE follows on the next cycle.
- When EN pulses back-to-back, only a pulse arriving in IDLE or OPEN is acted on. Pulses during RESTART or LOCKOUT are dropped and do not change `fail_cnt` or `miss_mask`.
- RST asserted mid-LOCKOUT or mid-OPEN aborts immediately. The next cycle shows the RESTART outputs with `fail_cnt`=0.

## Test plan
Bench parameters: DIGITS=4, MAX_FAIL=3, LOCK_CYCLES=16, RESTART_HOLD=2.

1. Reset and hold:
   - Stimulus: RST high for 3 cycles, then low.
   - Response: `restart`=1 during RST and for 2 further cycles, then 0. `unlocked`=0 and `fail_cnt`=0 throughout.
2. Correct code:
   - Stimulus: in IDLE, one-cycle EN with IN=4'b1111.
   - Response: next cycle `unlocked`=1, `restart`=0, `fail_cnt`=0. The state holds while EN stays low.
3. Single fail:
   - Stimulus: in IDLE, EN with IN=4'b1011.
   - Response: `restart`=1 for exactly 2 cycles, `fail_cnt`=1, `miss_mask`=4'b0100, then IDLE.
4. Lockout:
   - Stimulus: three failing checks in a row. During lockout, pulse EN with IN=4'b1111.
   - Response: `locked_out`=1 and `restart`=1 for exactly 16 cycles, `fail_cnt`=3, and the EN pulse is ignored. Afterwards the block is in IDLE with `fail_cnt`=0.
5. Fail counter cleared by success:
   - Stimulus: fail twice, then a correct check.
   - Response: `fail_cnt` goes 1, 2, then 0, and `unlocked`=1. No lockout occurs.
6. Relock and reset during lockout:
   - Stimulus: in OPEN, EN with IN=4'b0000. Separately, RST at lockout cycle 5.
   - Response: on the relock, `unlocked`→0 and `restart`=1 for 2 cycles, with `fail_cnt`=0. On the RST, `locked_out`→0 the next cycle, then the RESTART sequence runs with `fail_cnt`=0.
